wshb_rr_arbiter: RTL

//  Round-robin arbiter granting the shared SDRAM Wishbone master port to one of
//  NB_MASTERS requesters (VGA reader, pattern generator, future DMA, ...).

---
 rtl/wshb_rr_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/wshb_rr_arbiter.sv
// rtl/wshb_rr_arbiter.sv - round-robin Wishbone master arbiter with ack-count preemption
module wshb_rr_arbiter #(
    parameter int NB_MASTERS = 2,
    parameter int QUANTUM    = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NB_MASTERS-1:0]         cyc_i,
    input  logic                          ack_i,
    output logic [NB_MASTERS-1:0]         gnt_o,
    output logic [$clog2(NB_MASTERS)-1:0] gnt_idx_o,
    output logic                          busy_o
);

    localparam int IW = $clog2(NB_MASTERS);
    localparam int CW = (QUANTUM > 0) ? $clog2(QUANTUM + 1) : 1;
    localparam logic [CW-1:0] QMAX = CW'(QUANTUM);
    localparam logic [CW-1:0] QM1  = CW'((QUANTUM > 0) ? QUANTUM - 1 : 0);
    localparam logic [IW-1:0] LAST_RST = IW'(NB_MASTERS - 1);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t                  state_q, state_d;
    logic [NB_MASTERS-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [IW-1:0]           last_q, last_d;
    logic [CW-1:0]           ack_cnt_q, ack_cnt_d;

    logic [IW-1:0]           ref_idx;
    logic [IW-1:0]           win_idx;
    logic                    win_found;
    logic [NB_MASTERS-1:0]   win_onehot;
    logic                    others;
    logic                    release_req;
    logic                    preempt_req;
    int                      j;

    // Round-robin search starting just after the reference index, wrapping around.
    always_comb begin
        ref_idx    = (state_q == ST_IDLE) ? last_q : idx_q;
        win_found  = 1'b0;
        win_idx    = '0;
        j          = 0;
        for (int i = 1; i <= NB_MASTERS; i++) begin
            j = int'(ref_idx) + i;
            if (j >= NB_MASTERS) begin
                j = j - NB_MASTERS;
            end
            if (!win_found && cyc_i[j]) begin
                win_found = 1'b1;
                win_idx   = IW'(j);
            end
        end
        win_onehot          = '0;
        win_onehot[win_idx] = 1'b1;
    end

    always_comb begin
        others      = |(cyc_i & ~gnt_q);
        release_req = !cyc_i[idx_q];
        preempt_req = (QUANTUM != 0) && (ack_cnt_q >= QM1) && ack_i && others;
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        last_d    = last_q;
        ack_cnt_d = ack_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d   = ST_GRANT;
                    gnt_d     = win_onehot;
                    idx_d     = win_idx;
                    ack_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                if ((release_req || preempt_req) && others) begin
                    gnt_d     = win_onehot;
                    idx_d     = win_idx;
                    last_d    = idx_q;
                    ack_cnt_d = '0;
                end else if (release_req) begin
                    state_d   = ST_IDLE;
                    gnt_d     = '0;
                    last_d    = idx_q;
                    ack_cnt_d = '0;
                end else if (ack_i && (ack_cnt_q != QMAX)) begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            idx_q     <= '0;
            last_q    <= LAST_RST;
            ack_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            ack_cnt_q <= ack_cnt_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_idx_o = idx_q;
    assign busy_o    = (state_q == ST_GRANT);

endmodule
